castle_move_emitter: RTL and testbench

- Sequential stage directly downstream of the combinational castling detector.
- On a start pulse it snapshots the detector's 4-bit one-hot-per-slot valid vector and its 64-bit move bus. It then emits each valid castle move as a single 16-bit move word over a valid/ready handshake into the move-list FIFO of the move generator.
- It signals completion with a one-cycle done pulse and reports how many moves were emitted.

---
 rtl/castle_move_emitter_if.sv | 8 +
 rtl/castle_move_emitter.sv | 101 ++++++++++
 tb/tb_castle_move_emitter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/castle_move_emitter_if.sv
// castle_move_emitter_if: valid/ready move-word channel into the move-list FIFO
interface castle_move_emitter_if;
  logic [15:0] move_out;
  logic        move_valid;
  logic        move_ready;
  modport master (output move_out, move_valid, input move_ready);
  modport slave (input move_out, move_valid, output move_ready);
endinterface

// File: rtl/castle_move_emitter.sv
// castle_move_emitter: snapshots detected castle moves and streams them out one word per handshake
module castle_move_emitter #(
  parameter bit REVERSE   = 1'b0,
  parameter bit CHECK_FMT = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          flush,
  input  logic [3:0]                    castle_valid,
  input  logic [63:0]                   castle_moves,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    count,
  output logic                          drop_err,
  castle_move_emitter_if.master         m
);
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
  state_t      state_q;
  logic [3:0]  pending_q, fmt_ok, load_d, rem_d;
  logic [1:0]  sel_q, first_d, next_d;
  logic [63:0] moves_q;
  logic [15:0] move_out_q;
  logic        move_valid_q, done_q, drop_err_q, accept;
  logic [2:0]  count_q;

  function automatic logic [1:0] pick(input logic [3:0] v);
    if (REVERSE) return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction

  // format screen on the live bus, and the slot that follows the one being offered
  always_comb begin
    for (int i = 0; i < 4; i++) fmt_ok[i] = !CHECK_FMT || (castle_moves[16*i+14 +: 2] == 2'b01);
    load_d  = castle_valid & fmt_ok;
    rem_d   = pending_q & ~(4'b0001 << sel_q);
    first_d = pick(load_d);
    next_d  = pick(rem_d);
  end

  assign accept = move_valid_q && m.move_ready;

  // control FSM; flush overrides everything but still credits a move accepted on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      sel_q        <= '0;
      moves_q      <= '0;
      move_out_q   <= '0;
      move_valid_q <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
      drop_err_q   <= 1'b0;
    end else if (flush) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      move_valid_q <= 1'b0;
      done_q       <= 1'b0;
      if (state_q == EMIT && accept) count_q <= count_q + 3'd1;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            moves_q    <= castle_moves;
            pending_q  <= load_d;
            count_q    <= '0;
            drop_err_q <= |(castle_valid & ~fmt_ok);
            sel_q      <= first_d;
            move_out_q <= castle_moves[16*first_d +: 16];
            move_valid_q <= |load_d;
            done_q     <= ~|load_d;
            state_q    <= |load_d ? EMIT : DONE;
          end
        end
        EMIT: if (accept) begin
          count_q   <= count_q + 3'd1;
          pending_q <= rem_d;
          sel_q     <= next_d;
          if (|rem_d) move_out_q <= moves_q[16*next_d +: 16];
          move_valid_q <= |rem_d;
          done_q    <= ~|rem_d;
          state_q   <= |rem_d ? EMIT : DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = state_q != IDLE;
  assign done         = done_q;
  assign count        = count_q;
  assign drop_err     = drop_err_q;
  assign m.move_out   = move_out_q;
  assign m.move_valid = move_valid_q;
endmodule

// File: tb/tb_castle_move_emitter.sv
// tb_castle_move_emitter: directed scoreboard bench for forward and reverse emitters
module tb_castle_move_emitter;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0, ready = 1'b0;
  logic [3:0]  castle_valid = '0;
  logic [63:0] castle_moves = '0;
  logic        busy0, done0, drop0, busy1, done1, drop1;
  logic [2:0]  cnt0, cnt1;
  logic [15:0] q0[$], q1[$];
  logic [15:0] wq, wk, bq, bk, bad;
  logic [63:0] all4;
  int tests = 0, fails = 0;

  castle_move_emitter_if if0 ();
  castle_move_emitter_if if1 ();
  assign if0.move_ready = ready;
  assign if1.move_ready = ready;

  castle_move_emitter #(.REVERSE(1'b0), .CHECK_FMT(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .castle_valid(castle_valid),
    .castle_moves(castle_moves), .busy(busy0), .done(done0), .count(cnt0), .drop_err(drop0), .m(if0));
  castle_move_emitter #(.REVERSE(1'b1), .CHECK_FMT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .castle_valid(castle_valid),
    .castle_moves(castle_moves), .busy(busy1), .done(done1), .count(cnt1), .drop_err(drop1), .m(if1));

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [2:0] sc, sr, dc, dr);
    return {2'b01, 2'b00, sc, sr, dc, dr};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // score any handshake about to happen, then advance to 1ns after the next rising edge
  task automatic step();
    logic [15:0] e;
    if (if0.move_valid && ready) begin
      e = (q0.size() != 0) ? q0.pop_front() : 16'hxxxx;
      chk("fwd_move", {48'd0, if0.move_out}, {48'd0, e});
    end
    if (if1.move_valid && ready) begin
      e = (q1.size() != 0) ? q1.pop_front() : 16'hxxxx;
      chk("rev_move", {48'd0, if1.move_out}, {48'd0, e});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input logic [3:0] v, input logic [63:0] mv);
    castle_valid = v;
    castle_moves = mv;
    for (int i = 0; i < 4; i++) if (v[i] && mv[16*i+14 +: 2] == 2'b01) q0.push_back(mv[16*i +: 16]);
    for (int i = 3; i >= 0; i--) if (v[i] && mv[16*i+14 +: 2] == 2'b01) q1.push_back(mv[16*i +: 16]);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    wq = mk(3'd4, 3'd0, 3'd2, 3'd0);
    wk = mk(3'd4, 3'd0, 3'd6, 3'd0);
    bq = mk(3'd4, 3'd7, 3'd2, 3'd7);
    bk = mk(3'd4, 3'd7, 3'd6, 3'd7);
    bad = {2'b00, bq[13:0]};
    all4 = {bk, bq, wk, wq};
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_outs", {if0.move_out, if0.move_valid, busy0, done0, cnt0, drop0}, '0);
    chk("rst_outs_rev", {if1.move_valid, busy1, done1, cnt1, drop1}, '0);
    // single move
    ready = 1'b1;
    start_batch(4'b0001, all4);
    chk("single_valid", {if0.move_valid, busy0, if0.move_out}, {1'b1, 1'b1, wq});
    step();
    chk("single_done", {if0.move_valid, done0, cnt0}, {1'b0, 1'b1, 3'd1});
    step();
    chk("single_idle", {done0, busy0}, 2'b00);
    // full batch with back-pressure
    ready = 1'b0;
    start_batch(4'b1111, all4);
    for (int c = 0; c < 3; c++) begin
      chk("hold_fwd", {if0.move_valid, if0.move_out}, {1'b1, wq});
      chk("hold_rev", {if1.move_valid, if1.move_out}, {1'b1, bk});
      step();
    end
    ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("burst_valid", {if0.move_valid, if1.move_valid, done0}, 3'b110);
      step();
    end
    chk("full_done", {if0.move_valid, done0, cnt0, done1, cnt1}, {1'b0, 1'b1, 3'd4, 1'b1, 3'd4});
    chk("full_drained", q0.size() + q1.size(), 0);
    step();
    // empty batch
    start_batch(4'b0000, all4);
    chk("empty", {if0.move_valid, done0, cnt0, drop0}, {1'b0, 1'b1, 3'd0, 1'b0});
    step();
    // format drop
    start_batch(4'b0100, {bk, bad, wk, wq});
    chk("drop", {if0.move_valid, done0, cnt0, drop0, drop1}, {1'b0, 1'b1, 3'd0, 1'b1, 1'b1});
    step();
    // start and input changes during EMIT are ignored
    ready = 1'b0;
    start_batch(4'b0011, all4);
    chk("drop_cleared", drop0, 1'b0);
    castle_valid = 4'b1100;
    castle_moves = ~all4;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_start", {if0.move_valid, if0.move_out, cnt0}, {1'b1, wq, 3'd0});
    ready = 1'b1;
    step();
    step();
    chk("ign_done", {done0, cnt0, done1, cnt1}, {1'b1, 3'd2, 1'b1, 3'd2});
    chk("ign_drained", q0.size() + q1.size(), 0);
    step();
    // flush mid-batch
    start_batch(4'b1111, all4);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush", {if0.move_valid, done0, busy0, cnt0, cnt1}, {1'b0, 1'b0, 1'b0, 3'd2, 3'd2});
    q0.delete();
    q1.delete();
    step();
    chk("flush_nodone", {done0, busy0}, 2'b00);
    start_batch(4'b0010, all4);
    chk("post_flush", {if0.move_valid, if0.move_out}, {1'b1, wk});
    step();
    chk("post_flush_done", {done0, cnt0}, {1'b1, 3'd1});
    step();
    // asynchronous reset mid-batch
    ready = 1'b0;
    start_batch(4'b1111, all4);
    chk("pre_reset_busy", busy0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {if0.move_valid, busy0, done0, cnt0, if1.move_valid, busy1}, '0);
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b1;
    start_batch(4'b1000, all4);
    chk("after_rst", {if0.move_out, if1.move_out}, {bk, bk});
    step();
    chk("after_rst_done", {done0, cnt0, if0.move_valid}, {1'b1, 3'd1, 1'b0});
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
